// File: rtl/seg_add_seq.sv
// seg_add_seq: performs one DATA_W-bit add over NSEG cycles on a shared SEG_W-bit external adder
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake; a, b, ci captured on accept
//   acc                 (only with SEG_ADD_ACCUM_EN) load b operand from current sum
//   out_valid/out_ready result handshake; sum, cout registered result
//   busy                high while an operation is running or its result is pending
//   add_a/add_b/add_ci  segment operands to the external adder
//   add_s/add_cout      segment result from the external adder
// Optional feature macro: SEG_ADD_ACCUM_EN
module seg_add_seq #(
  parameter int SEG_W = 256,
  parameter int NSEG  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEG_W*NSEG-1:0] a,
  input  logic [SEG_W*NSEG-1:0] b,
  input  logic                  ci,
`ifdef SEG_ADD_ACCUM_EN
  input  logic                  acc,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEG_W*NSEG-1:0] sum,
  output logic                  cout,
  output logic                  busy,
  output logic [SEG_W-1:0]      add_a,
  output logic [SEG_W-1:0]      add_b,
  output logic                  add_ci,
  input  logic [SEG_W-1:0]      add_s,
  input  logic                  add_cout
);
  localparam int DATA_W = SEG_W * NSEG;
  localparam int CW = $clog2(NSEG);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] seg_q, seg_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic ci_q, ci_d, carry_q, carry_d, cout_q, cout_d;
  logic last_seg;
  assign last_seg = seg_q == CW'(NSEG - 1);
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign sum = sum_q;
  assign cout = cout_q;
  // Adder inputs are forced to zero outside RUN so the shared adder sees quiet operands
  assign add_a = state_q == RUN ? a_q[seg_q*SEG_W +: SEG_W] : '0;
  assign add_b = state_q == RUN ? b_q[seg_q*SEG_W +: SEG_W] : '0;
  assign add_ci = state_q == RUN ? (seg_q == '0 ? ci_q : carry_q) : 1'b0;
  always_comb begin
    state_d = state_q;
    seg_d = seg_q;
    a_d = a_q;
    b_d = b_q;
    ci_d = ci_q;
    carry_d = carry_q;
    sum_d = sum_q;
    cout_d = cout_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = a;
`ifdef SEG_ADD_ACCUM_EN
        b_d = acc ? sum_q : b;
`else
        b_d = b;
`endif
        ci_d = ci;
        seg_d = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[seg_q*SEG_W +: SEG_W] = add_s;
        carry_d = add_cout;
        // Counter stops on the last segment so it never wraps within an operation
        seg_d = last_seg ? seg_q : seg_q + 1'b1;
        cout_d = last_seg ? add_cout : cout_q;
        state_d = last_seg ? DONE : RUN;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      seg_q <= '0;
      a_q <= '0;
      b_q <= '0;
      ci_q <= 1'b0;
      carry_q <= 1'b0;
      sum_q <= '0;
      cout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q <= seg_d;
      a_q <= a_d;
      b_q <= b_d;
      ci_q <= ci_d;
      carry_q <= carry_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
    end
  end
endmodule
